// File: rtl/dmem_mmio.sv
// Data-memory responder: word-addressed RAM plus a small MMIO block in the top 64 KiB
// (cycle counter, scratch, console TX FIFO, tohost halt). Reads are combinational.
module dmem_mmio #(
    parameter int RAM_WORDS = 1024,
    parameter int CON_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dm_wen_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_din_i,
    output logic [31:0] dm_dout_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        halt_o,
    output logic [31:0] exit_code_o
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(CON_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(CON_DEPTH);

    localparam logic [7:0] OFF_CYCLE      = 8'h00;
    localparam logic [7:0] OFF_CON_DATA   = 8'h04;
    localparam logic [7:0] OFF_CON_STATUS = 8'h08;
    localparam logic [7:0] OFF_SCRATCH    = 8'h0C;
    localparam logic [7:0] OFF_TOHOST     = 8'h10;

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [CON_DEPTH];

    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   scratch_q, scratch_d;
    logic [31:0]   exit_q, exit_d;
    logic          halt_q, halt_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic          is_mmio, mmio_wr;
    logic [7:0]    off;
    logic [AW-1:0] ram_idx;
    logic          empty, full, pop, push_req, push_ok, ovf_clr;

    assign is_mmio  = (dm_addr_i[31:16] == 16'hFFFF);
    assign off      = dm_addr_i[7:0];
    assign ram_idx  = dm_addr_i[AW+1:2];
    assign mmio_wr  = dm_wen_i & is_mmio;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_FULL);
    assign pop      = ~empty & con_ready_i;
    assign push_req = mmio_wr & (off == OFF_CON_DATA);
    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_clr  = mmio_wr & (off == OFF_CON_STATUS) & dm_din_i[2];

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        halt_d    = halt_q;
        exit_d    = exit_q;
        ovf_d     = ovf_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        if (mmio_wr && off == OFF_SCRATCH) begin
            scratch_d = dm_din_i;
        end
        if (mmio_wr && off == OFF_TOHOST && !halt_q) begin
            halt_d = 1'b1;
            exit_d = dm_din_i;
        end
        // A new overflow outranks a clear issued in the same cycle.
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            exit_q    <= '0;
            halt_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            exit_q    <= exit_d;
            halt_q    <= halt_d;
            ovf_q     <= ovf_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage arrays are deliberately unreset; RAM survives a mid-run reset.
    always_ff @(posedge clk_i) begin
        if (dm_wen_i && !is_mmio) begin
            ram[ram_idx] <= dm_din_i;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= dm_din_i[7:0];
        end
    end

    always_comb begin
        dm_dout_o = '0;
        if (!is_mmio) begin
            dm_dout_o = ram[ram_idx];
        end else begin
            case (off)
                OFF_CYCLE:      dm_dout_o = cycle_q;
                OFF_CON_STATUS: dm_dout_o = {29'b0, ovf_q, full, empty};
                OFF_SCRATCH:    dm_dout_o = scratch_q;
                OFF_TOHOST:     dm_dout_o = exit_q;
                default:        dm_dout_o = '0;
            endcase
        end
    end

    assign con_valid_o = ~empty;
    assign con_data_o  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory responder at the far end of the core's data-memory port: it accepts the word address, write enable and write data the core drives each cycle, and returns read data combinationally in the same cycle, ready for the core to register at the next edge. Non-MMIO addresses go to a word-addressed RAM. The top 64 KiB of the address space is a small MMIO block: cycle counter, scratch register, console TX FIFO with a ready/valid drain port, and a tohost halt register for simulation and FPGA bring-up.

## Interface
Parameters:
- RAM_WORDS, 1024: RAM depth in 32-bit words; power of two, ≥ 2.
- CON_DEPTH, 8: console FIFO depth in bytes; power of two, ≥ 2.

Ports:
- clk_i  in  1  single clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- dm_wen_i  in  1  write strobe; 1 = write this cycle, 0 = read.
- dm_addr_i  in  32  byte address; bits [1:0] ignored.
- dm_din_i  in  32  write data.
- dm_dout_o  out  32  read data, combinational from dm_addr_i and current state.
- con_valid_o  out  1  console byte available (FIFO not empty).
- con_data_o  out  8  FIFO head byte; 0 when empty.
- con_ready_i  in  1  consumer accepts the head byte when con_valid_o is also 1.
- halt_o  out  1  sticky; set by the first tohost write.
- exit_code_o  out  32  data captured by the first tohost write.

## Operation
- Decode: MMIO when dm_addr_i[31:16] == 16'hFFFF; otherwise RAM.
- RAM index is dm_addr_i[log2(RAM_WORDS)+1:2]; higher address bits are ignored, so addresses alias (wrap).
- RAM is not reset; contents are X until written.
- Writes commit at the rising edge when dm_wen_i = 1.
- Reads return the array word combinationally. A read in the same cycle as a write to the same word returns the old data.
- MMIO offsets, decoded on dm_addr_i[7:0]; other offsets read 0 and ignore writes:
  - 0x00 CYCLE: read-only. 32-bit counter, increments every cycle, wraps FFFF_FFFF -> 0.
  - 0x04 CON_DATA:
    - Write pushes dm_din_i[7:0].
    - Push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
    - Otherwise the byte is dropped and OVF is set.
    - Reads return 0.
  - 0x08 CON_STATUS: read {29'b0, OVF, FULL, EMPTY}. Writing with dm_din_i[2] = 1 clears OVF; other bits are ignored.
  - 0x0C SCRATCH: 32-bit read/write.
  - 0x10 TOHOST:
    - First write sets halt_o = 1 and exit_code_o = dm_din_i; later writes are ignored.
    - Read returns exit_code_o.
- Console FIFO:
  - Circular buffer with log2(CON_DEPTH)-bit read/write pointers (wrapping) and a count of width log2(CON_DEPTH)+1.
  - Pop occurs when con_valid_o & con_ready_i.
  - Simultaneous push and pop leaves count unchanged.
  - Pop on empty is impossible by construction.
  - No fall-through: a byte pushed into an empty FIFO is visible next cycle.
- An OVF clear and a new overflow in the same cycle: OVF ends at 1 (set wins).

## Timing
- Reset values, all asserted asynchronously:
  - CYCLE = 0, SCRATCH = 0, exit_code_o = 0, halt_o = 0.
  - FIFO pointers and count = 0, OVF = 0.
  - Hence con_valid_o = 0 and con_data_o = 0.
  - dm_dout_o reflects the reset state (MMIO reads 0); RAM reads return array contents.
- Reset asserted mid-operation flushes the FIFO, discarding unread bytes, and clears halt. RAM keeps its contents.
- CYCLE reads 0 in the first cycle after reset deassertion, 1 in the next, and so on.
- Read latency is 0 cycles, combinational. A value written at edge N is readable in cycle N+1 (after edge N).
- Status bits and con_valid_o update at the edge after a push or pop.
- halt_o rises at the edge that commits the tohost write.

## Test plan
- Write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0040 and its alias 0x0000_0040 + 4·RAM_WORDS -> both return 0xDEADBEEF. A same-cycle read of the word during a write of 0x1 returns the old value.
- Release reset and read CYCLE at cycles 0, 1 and 5 -> 0, 1, 5. Force the counter to 0xFFFF_FFFF -> next read 0.
- Push 'A'..'H' (CON_DEPTH = 8) with con_ready_i = 0 -> STATUS = 0x2. Push 'I' -> STATUS = 0x6, 'I' dropped. Raise con_ready_i -> 'A'..'H' drain in order, one per cycle, then STATUS = 0x5. Write STATUS with 0x4 -> STATUS = 0x1.
- FIFO full, push 'Z' in the same cycle as a pop -> accepted, count stays 8, OVF stays 0, 'Z' is delivered last.
- Write SCRATCH = 0x12345678 and read back. Write TOHOST = 0x1 then 0x2 -> halt_o = 1, exit_code_o = 0x1. Read 0xFFFF_0020 -> 0.
- Assert rst_i mid-drain with 3 bytes queued -> con_valid_o = 0 immediately, halt_o = 0, SCRATCH = 0, previously written RAM word unchanged.
